// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator sequencer: instruction format,
// opcodes, FSM state encoding and the decoded-control bundle.
package bip_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef struct packed {
        logic is_hlt;
        logic rd_mem;
        logic wr_mem;
        logic use_imm;
        logic use_bau;
        logic load_acc;
        logic op_add;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: maps a 5-bit opcode to the control bundle
// used by the sequencer. Undefined opcodes behave as NOP and flag illegal.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output dec_t             dec_o
);

    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OPC_HLT:  dec_o.is_hlt = 1'b1;
            OPC_STO:  dec_o.wr_mem = 1'b1;
            OPC_LD: begin
                dec_o.rd_mem   = 1'b1;
                dec_o.load_acc = 1'b1;
            end
            OPC_LDI: begin
                dec_o.use_imm  = 1'b1;
                dec_o.load_acc = 1'b1;
            end
            OPC_ADD: begin
                dec_o.rd_mem   = 1'b1;
                dec_o.use_bau  = 1'b1;
                dec_o.load_acc = 1'b1;
                dec_o.op_add   = 1'b1;
            end
            OPC_ADDI: begin
                dec_o.use_imm  = 1'b1;
                dec_o.use_bau  = 1'b1;
                dec_o.load_acc = 1'b1;
                dec_o.op_add   = 1'b1;
            end
            OPC_SUB: begin
                dec_o.rd_mem   = 1'b1;
                dec_o.use_bau  = 1'b1;
                dec_o.load_acc = 1'b1;
            end
            OPC_SUBI: begin
                dec_o.use_imm  = 1'b1;
                dec_o.use_bau  = 1'b1;
                dec_o.load_acc = 1'b1;
            end
            default:  dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_sequencer.sv
// Multi-cycle BIP control unit: FETCH/DECODE/EXEC/WB sequencing, owns PC/IR/ACC.
// Optional BIP_CYCLE_COUNT_EN adds a 32-bit active-cycle counter output.
// Memory handshake: imem_data/dmem_rdata are sampled one cycle after the
// address/read strobe (synchronous memories); dmem_wr commits on the EXEC edge.
module bip_sequencer
    import bip_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int PC_W   = 11,
    parameter int ADDR_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic               dmem_rd,
    output logic               dmem_wr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               bau_op,
    output logic [DATA_W-1:0]  bau_a,
    output logic [DATA_W-1:0]  bau_b,
    input  logic [DATA_W-1:0]  bau_result,
    output logic [DATA_W-1:0]  acc,
    output logic               halted,
    output logic               illegal,
`ifdef BIP_CYCLE_COUNT_EN
    output logic [31:0]        cycle_cnt,
`endif
    output state_e             dbg_state
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [OPC_W-1:0]    dec_opc;
    logic [DATA_W-1:0]   imm;
    dec_t                dec;

    // In DECODE the instruction is still on the ROM bus; afterwards it lives in IR.
    assign dec_opc = (state_q == ST_DECODE) ? imem_data[INSTR_W-1 -: OPC_W]
                                            : ir_q[INSTR_W-1 -: OPC_W];
    assign imm     = DATA_W'($signed(ir_q[ADDR_W-1:0]));

    bip_decoder u_dec (
        .opcode_i (dec_opc),
        .dec_o    (dec)
    );

    assign imem_addr  = pc_q;
    assign dmem_addr  = ir_q[ADDR_W-1:0];
    assign dmem_wdata = acc_q;
    assign bau_op     = dec.op_add;
    assign bau_a      = acc_q;
    assign bau_b      = dec.use_imm ? imm : dmem_rdata;
    assign acc        = acc_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                ST_FETCH:  state_d = ST_DECODE;
                ST_DECODE: state_d = dec.is_hlt ? ST_HALT : ST_EXEC;
                ST_EXEC:   state_d = ST_WB;
                ST_WB:     state_d = ST_FETCH;
                default:   state_d = ST_HALT;
            endcase
        end
    end

    always_comb begin
        dmem_rd = 1'b0;
        dmem_wr = 1'b0;
        illegal = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_EXEC: begin
                dmem_rd = run & dec.rd_mem;
                dmem_wr = run & dec.wr_mem;
            end
            ST_WB:   illegal = run & dec.illegal;
            ST_HALT: halted  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        acc_d = acc_q;
        if (run) begin
            if (state_q == ST_DECODE) ir_d = imem_data;
            if (state_q == ST_WB) begin
                pc_d = pc_q + PC_W'(1);
                if (dec.load_acc) acc_d = dec.use_bau ? bau_result : bau_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ir_q  <= '0;
            acc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            acc_q <= acc_d;
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d     = (run && state_q != ST_HALT) ? cnt_q + 32'd1 : cnt_q;
    assign cycle_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule
